// File: rtl/ctr_cipher_packer.sv
// ctr_cipher_packer
// Assembles a stream of WORDW-bit ciphertext words into one CIPHERTEXTIN-bit
// frame for the AES-256 CTR decryption stage. Word 0 occupies the least
// significant slot, so 128-bit block k sits at bits [k*128+127 : k*128].
// Once the frame is complete it is held stable and ctrenable_o stays high
// until the decryptor pulses consume_i.
//
// Build option:
//   CTR_PACK_BSWAP_EN - when defined, each accepted word is byte-reversed
//                       before storage (WORDW must be a multiple of 8).
//                       When undefined, words are stored as received.
//                       Timing and control behaviour do not change.

module ctr_cipher_packer #(
  parameter int CIPHERTEXTIN = 1024,
  parameter int WORDW        = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [WORDW-1:0]                          word_i,
  input  logic                                      word_valid_i,
  output logic                                      word_ready_o,
  input  logic                                      flush_i,
  input  logic                                      consume_i,
  output logic [CIPHERTEXTIN-1:0]                   ciphertext_o,
  output logic                                      ctrenable_o,
  output logic [$clog2(CIPHERTEXTIN/WORDW+1)-1:0]   word_count_o
);

  localparam int NWORDS = CIPHERTEXTIN / WORDW;
  localparam int CNTW   = $clog2(NWORDS + 1);

  // Two-state controller: collecting words, or holding a complete frame.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                  state_r;
  logic [CNTW-1:0]         cnt_r;
  logic [CIPHERTEXTIN-1:0] frame_r;
  logic                    ctrenable_r;

  logic                    accept_s;
  logic                    last_word_s;
  logic [WORDW-1:0]        store_word_s;

  // Byte-reverse a word: the lowest input byte lands in the top byte.
  function automatic logic [WORDW-1:0] byte_reverse(input logic [WORDW-1:0] w);
    logic [WORDW-1:0] r;
    r = '0;
    for (int b = 0; b < WORDW / 8; b++) begin
      r[b*8 +: 8] = w[WORDW-8-b*8 +: 8];
    end
    return r;
  endfunction

  // Ready only while collecting; forced low during reset so nothing is
  // handshaken in a cycle whose edge will discard it anyway.
  assign word_ready_o = (state_r == ST_FILL) & ~rst;

  // Select the storage form of the incoming word and qualify the handshake.
  // A word offered alongside flush_i is dropped even though ready is high.
  always_comb begin
    accept_s     = 1'b0;
    last_word_s  = 1'b0;
    store_word_s = word_i;
`ifdef CTR_PACK_BSWAP_EN
    store_word_s = byte_reverse(word_i);
`else
    store_word_s = word_i;
`endif
    if (word_valid_i && word_ready_o && !flush_i) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (cnt_r == CNTW'(NWORDS - 1)) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
  end

  // Frame assembly and fill/full control; flush wins over consume and words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FILL;
      cnt_r       <= '0;
      frame_r     <= '0;
      ctrenable_r <= 1'b0;
    end else if (flush_i) begin
      // Frame bits are intentionally left in place; only the count restarts.
      state_r     <= ST_FILL;
      cnt_r       <= '0;
      ctrenable_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            // Slot decode by compare keeps the write inside the frame even
            // if the count were ever corrupted to an out-of-range value.
            for (int i = 0; i < NWORDS; i++) begin
              if (cnt_r == CNTW'(i)) begin
                frame_r[i*WORDW +: WORDW] <= store_word_s;
              end
            end
            cnt_r <= cnt_r + CNTW'(1);
            if (last_word_s) begin
              state_r     <= ST_FULL;
              ctrenable_r <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          // Frame is frozen here; old contents stay until overwritten.
          if (consume_i) begin
            state_r     <= ST_FILL;
            cnt_r       <= '0;
            ctrenable_r <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty frame.
          state_r     <= ST_FILL;
          cnt_r       <= '0;
          ctrenable_r <= 1'b0;
        end
      endcase
    end
  end

  assign ciphertext_o = frame_r;
  assign ctrenable_o  = ctrenable_r;
  assign word_count_o = cnt_r;

endmodule

// File: tb/tb_ctr_cipher_packer.sv
// Scoreboard bench for ctr_cipher_packer with default parameters.
// Expected frames are queued by the stimulus; a monitor pops and compares
// each time the packer raises ctrenable_o.

module tb_ctr_cipher_packer;

  localparam int FW = 1024;
  localparam int WW = 32;
  localparam int NW = FW / WW;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] word_i;
  logic          word_valid_i;
  logic          word_ready_o;
  logic          flush_i;
  logic          consume_i;
  logic [FW-1:0] ciphertext_o;
  logic          ctrenable_o;
  logic [5:0]    word_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [FW-1:0] exp_q[$];
  logic          prev_en = 1'b0;
  logic [FW-1:0] exp_frame;

  ctr_cipher_packer #(.CIPHERTEXTIN(FW), .WORDW(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .flush_i      (flush_i),
    .consume_i    (consume_i),
    .ciphertext_o (ciphertext_o),
    .ctrenable_o  (ctrenable_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  // Storage form of a word, depending on the build option.
  function automatic logic [WW-1:0] stored(input logic [WW-1:0] w);
`ifdef CTR_PACK_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word and let the next edge take it.
  task automatic send(input logic [WW-1:0] w);
    word_i       = w;
    word_valid_i = 1'b1;
    #1;
    chk("ready_before_accept", FW'(word_ready_o), FW'(1'b1));
    tick();
  endtask

  task automatic idle(input int n);
    word_valid_i = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: compare the held frame against the scoreboard on each new frame.
  always @(negedge clk) begin
    if (ctrenable_o === 1'b1 && prev_en !== 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got %0h expected no frame", ciphertext_o);
      end else begin
        logic [FW-1:0] e;
        e = exp_q.pop_front();
        if (ciphertext_o !== e) begin
          n_fail++;
          $display("FAIL frame_data: got %0h expected %0h", ciphertext_o, e);
        end
      end
    end
    prev_en <= ctrenable_o;
  end

  initial begin
    rst = 1'b1; word_valid_i = 1'b1; word_i = 32'hFFFF_FFFF;
    flush_i = 1'b0; consume_i = 1'b0;
    #1;
    chk("ready_in_reset", FW'(word_ready_o), FW'(1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_ready", FW'(word_ready_o), FW'(1'b0));
      chk("rst_frame", ciphertext_o, '0);
      chk("rst_en", FW'(ctrenable_o), FW'(1'b0));
      chk("rst_count", FW'(word_count_o), FW'(6'd0));
    end
    rst = 1'b0; word_valid_i = 1'b0;
    #1;
    chk("ready_after_release", FW'(word_ready_o), FW'(1'b1));

    // Frame 1: back-to-back words 0..31.
    exp_frame = '0;
    for (int i = 0; i < NW; i++) exp_frame[i*WW +: WW] = stored(WW'(i));
    exp_q.push_back(exp_frame);
    for (int i = 0; i < NW; i++) send(WW'(i));
    chk("f1_en", FW'(ctrenable_o), FW'(1'b1));
    chk("f1_ready", FW'(word_ready_o), FW'(1'b0));
    chk("f1_count", FW'(word_count_o), FW'(6'd32));
    chk("f1_lo", FW'(ciphertext_o[31:0]), FW'(stored(32'h0000_0000)));
    chk("f1_hi", FW'(ciphertext_o[1023:992]), FW'(stored(32'h0000_001F)));
    word_i = 32'hFFFF_FFFF; word_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("f1_frozen", ciphertext_o, exp_frame);
    chk("f1_count_hold", FW'(word_count_o), FW'(6'd32));
    word_valid_i = 1'b0; consume_i = 1'b1;
    tick();
    consume_i = 1'b0;
    chk("c1_en", FW'(ctrenable_o), FW'(1'b0));
    chk("c1_ready", FW'(word_ready_o), FW'(1'b1));
    chk("c1_count", FW'(word_count_o), FW'(6'd0));

    // Frame 2: A5A5A5A5 words with 1-3 cycle bubbles, consume in 4th FULL cycle.
    exp_frame = '0;
    for (int i = 0; i < NW; i++) exp_frame[i*WW +: WW] = stored(32'hA5A5_A5A5);
    exp_q.push_back(exp_frame);
    for (int i = 0; i < NW; i++) begin
      send(32'hA5A5_A5A5);
      if (i != NW - 1) idle((i % 3) + 1);
    end
    word_valid_i = 1'b0;
    chk("f2_count_mid", FW'(word_count_o), FW'(6'd32));
    idle(3);
    chk("f2_en_hold", FW'(ctrenable_o), FW'(1'b1));
    consume_i = 1'b1;
    tick();
    consume_i = 1'b0;
    chk("c2_en", FW'(ctrenable_o), FW'(1'b0));
    chk("c2_ready", FW'(word_ready_o), FW'(1'b1));
    chk("c2_count", FW'(word_count_o), FW'(6'd0));
    chk("c2_frame_kept", ciphertext_o, exp_frame);

    // Flush mid-fill with a word offered in the same cycle.
    for (int i = 0; i < 5; i++) send(WW'(32'h200 + i));
    chk("fl_count5", FW'(word_count_o), FW'(6'd5));
    word_i = 32'hDEAD_BEEF; word_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; word_valid_i = 1'b0;
    chk("fl_count", FW'(word_count_o), FW'(6'd0));
    chk("fl_en", FW'(ctrenable_o), FW'(1'b0));
    chk("fl_slot5_kept", FW'(ciphertext_o[191:160]), FW'(stored(32'hA5A5_A5A5)));
    chk("fl_slot0_kept", FW'(ciphertext_o[31:0]), FW'(stored(32'h0000_0200)));

    // Frame 3: 0x100+i, no residue from before the flush.
    exp_frame = '0;
    for (int i = 0; i < NW; i++) exp_frame[i*WW +: WW] = stored(WW'(32'h100 + i));
    exp_q.push_back(exp_frame);
    for (int i = 0; i < NW; i++) send(WW'(32'h100 + i));
    word_valid_i = 1'b0;
    chk("f3_lo", FW'(ciphertext_o[31:0]), FW'(stored(32'h0000_0100)));
    chk("f3_en", FW'(ctrenable_o), FW'(1'b1));
    tick();

    // Flush and consume together in FULL.
    flush_i = 1'b1; consume_i = 1'b1;
    tick();
    flush_i = 1'b0; consume_i = 1'b0;
    chk("fc_en", FW'(ctrenable_o), FW'(1'b0));
    chk("fc_count", FW'(word_count_o), FW'(6'd0));
    chk("fc_ready", FW'(word_ready_o), FW'(1'b1));

    // Consume while filling is ignored.
    for (int i = 0; i < 3; i++) send(WW'(32'h400 + i));
    word_valid_i = 1'b0; consume_i = 1'b1;
    tick();
    consume_i = 1'b0;
    chk("consume_in_fill", FW'(word_count_o), FW'(6'd3));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // Reset mid-fill at count 17.
    for (int i = 0; i < 17; i++) send(WW'(32'h300 + i));
    word_valid_i = 1'b0;
    chk("mr_count17", FW'(word_count_o), FW'(6'd17));
    rst = 1'b1;
    tick();
    chk("mr_ready", FW'(word_ready_o), FW'(1'b0));
    chk("mr_frame", ciphertext_o, '0);
    chk("mr_en", FW'(ctrenable_o), FW'(1'b0));
    chk("mr_count", FW'(word_count_o), FW'(6'd0));
    rst = 1'b0;
    #1;

    // Byte order of word 0.
    send(32'h1122_3344);
    word_valid_i = 1'b0;
`ifdef CTR_PACK_BSWAP_EN
    chk("bswap_w0", FW'(ciphertext_o[31:0]), FW'(32'h4433_2211));
`else
    chk("bswap_w0", FW'(ciphertext_o[31:0]), FW'(32'h1122_3344));
`endif
    chk("bswap_count", FW'(word_count_o), FW'(6'd1));

    idle(2);
    chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus expected completion");
    $fatal(1);
  end

endmodule
